// File: rtl/fifo_flex.sv
// Valid/ready FIFO with arbitrary depth, optional empty-bypass path, synchronous flush,
// registered fill count and programmable almost-full/almost-empty flags.

module fifo_flex_chk #(
    parameter int DEPTH  = 8,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count,
    input logic             wr,
    input logic             rd
);
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (rd && (count == '0)) |-> (BYPASS && wr));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (wr && (count == CNT_W'(DEPTH))) |-> rd);
endmodule

module fifo_flex #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter bit BYPASS = 1'b1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] af_level,
    input  logic [CNT_W-1:0] ae_level,
    output logic             almost_full,
    output logic             almost_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    // Depth need not be a power of two, so wrap explicitly at the last slot.
    function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            f_ptr_next = '0;
        end else begin
            f_ptr_next = ptr + PTR_W'(1);
        end
    endfunction

    // Handshake decode: reset and flush block both sides for the whole cycle.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(DEPTH));
        if (rst || flush) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end else if (BYPASS) begin
            out_valid = !w_empty || in_valid;
            in_ready  = !w_full || out_ready;
        end else begin
            out_valid = !w_empty;
            in_ready  = !w_full;
        end
        if (BYPASS && w_empty) begin
            out_data = in_data;
        end else begin
            out_data = r_mem[r_rd_ptr];
        end
        w_wr = in_valid && in_ready;
        w_rd = out_valid && out_ready;
    end

    // Pointer and occupancy state; a pass-through moves both pointers so net state is unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= f_ptr_next(r_rd_ptr);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= af_level);
    assign almost_empty = (r_count <= ae_level);

    fifo_flex_chk #(
        .DEPTH  (DEPTH),
        .BYPASS (BYPASS),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (r_count),
        .wr    (w_wr),
        .rd    (w_rd)
    );
endmodule

// File: tb/tb_fifo_flex.sv
// Two depth-5 FIFOs (registered and bypass) share one stimulus stream; a queue model
// per instance predicts every output each cycle, with directed literal checks on top.

module tb_fifo_flex;
    localparam int D = 5;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] af_level;
    logic [2:0] ae_level;

    logic       a_in_ready, a_out_valid, a_af, a_ae;
    logic [7:0] a_out_data;
    logic [2:0] a_count;
    logic       b_in_ready, b_out_valid, b_af, b_ae;
    logic [7:0] b_out_data;
    logic [2:0] b_count;

    int  checks  = 0;
    int  errors  = 0;
    bit  started = 1'b0;
    bit  wa = 1'b0, ra = 1'b0, wb = 1'b0, rb = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    fifo_flex #(.WIDTH(8), .DEPTH(D), .BYPASS(1'b0)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .count(a_count), .af_level(af_level), .ae_level(ae_level),
        .almost_full(a_af), .almost_empty(a_ae)
    );

    fifo_flex #(.WIDTH(8), .DEPTH(D), .BYPASS(1'b1)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .count(b_count), .af_level(af_level), .ae_level(ae_level),
        .almost_full(b_af), .almost_empty(b_ae)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected behaviour of one instance from its queue contents and the live inputs.
    task automatic cmp_dut(input string tag, input bit byp, input int sz, input logic [7:0] head,
                           input logic d_rdy, input logic d_val, input logic [7:0] d_data,
                           input logic [2:0] d_cnt, input logic d_af, input logic d_ae,
                           output bit wr, output bit rd);
        bit e_rdy, e_val;
        logic [7:0] e_data;
        if (rst || flush) begin
            e_rdy = 1'b0;
            e_val = 1'b0;
        end else if (byp) begin
            e_val = (sz > 0) || in_valid;
            e_rdy = (sz < D) || out_ready;
        end else begin
            e_val = (sz > 0);
            e_rdy = (sz < D);
        end
        e_data = (sz == 0) ? in_data : head;
        chk({tag, ".in_ready"}, 32'(d_rdy), 32'(e_rdy));
        chk({tag, ".out_valid"}, 32'(d_val), 32'(e_val));
        if (e_val) chk({tag, ".out_data"}, 32'(d_data), 32'(e_data));
        chk({tag, ".count"}, 32'(d_cnt), 32'(sz));
        chk({tag, ".almost_full"}, 32'(d_af), 32'(sz >= int'(af_level)));
        chk({tag, ".almost_empty"}, 32'(d_ae), 32'(sz <= int'(ae_level)));
        wr = in_valid && e_rdy;
        rd = e_val && out_ready;
    endtask

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp_dut("A", 1'b0, qa.size(), (qa.size() > 0) ? qa[0] : 8'h00,
                    a_in_ready, a_out_valid, a_out_data, a_count, a_af, a_ae, wa, ra);
            cmp_dut("B", 1'b1, qb.size(), (qb.size() > 0) ? qb[0] : 8'h00,
                    b_in_ready, b_out_valid, b_out_data, b_count, b_af, b_ae, wb, rb);
        end
    end

    // Model state update at the active edge.
    always @(posedge clk) begin
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (wa) qa.push_back(in_data);
            if (ra) void'(qa.pop_front());
            if (wb) qb.push_back(in_data);
            if (rb) void'(qb.pop_front());
        end
        wa = 1'b0; ra = 1'b0; wb = 1'b0; rb = 1'b0;
        started = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = base + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    logic [7:0] exp3 [5];
    int pv, pr;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h00;
        af_level = 3'd4; ae_level = 3'd1;
        exp3[0] = 8'h11; exp3[1] = 8'h12; exp3[2] = 8'h13; exp3[3] = 8'h14; exp3[4] = 8'h20;
        tick(); tick();
        #1;
        chk("rst.a_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst.b_out_valid", 32'(b_out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst.a_count", 32'(a_count), 32'd0);
        chk("post_rst.a_in_ready", 32'(a_in_ready), 32'd1);
        chk("post_rst.b_out_valid", 32'(b_out_valid), 32'd0);

        // Empty pass-through versus one-cycle registered latency
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        chk("byp.b_out_valid", 32'(b_out_valid), 32'd1);
        chk("byp.b_out_data", 32'(b_out_data), 32'hA5);
        chk("byp.a_out_valid", 32'(a_out_valid), 32'd0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("byp.b_count", 32'(b_count), 32'd0);
        chk("lat.a_count", 32'(a_count), 32'd1);
        chk("lat.a_out_valid", 32'(a_out_valid), 32'd1);
        chk("lat.a_out_data", 32'(a_out_data), 32'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill/drain three times to cross the 4->0 pointer wrap; flags checked on the first fill
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1;
            for (int i = 1; i <= D; i++) begin
                in_data = 8'(r * 16 + i);
                if (r == 0) begin
                    #1;
                    chk("flag.ae", 32'(a_ae), 32'((i - 1) <= 1));
                    chk("flag.af", 32'(a_af), 32'((i - 1) >= 4));
                end
                tick();
            end
            in_valid = 1'b0;
            #1;
            chk("full.a_count", 32'(a_count), 32'd5);
            chk("full.a_in_ready", 32'(a_in_ready), 32'd0);
            chk("full.b_in_ready", 32'(b_in_ready), 32'd0);
            if (r == 0) begin
                chk("full.af", 32'(a_af), 32'd1);
                af_level = 3'd6;
                #1;
                chk("full.af_raised", 32'(a_af), 32'd0);
                af_level = 3'd4;
            end
            out_ready = 1'b1;
            for (int i = 1; i <= D; i++) begin
                #1;
                chk("order.a", 32'(a_out_data), 32'(r * 16 + i));
                chk("order.b", 32'(b_out_data), 32'(r * 16 + i));
                tick();
            end
            out_ready = 1'b0;
            #1;
            chk("drained.a_count", 32'(a_count), 32'd0);
            chk("drained.b_count", 32'(b_count), 32'd0);
        end

        // Full with simultaneous read and write
        fill(8'h10, D);
        in_valid = 1'b1; in_data = 8'h20; out_ready = 1'b1;
        #1;
        chk("fullrw.b_out_data", 32'(b_out_data), 32'h10);
        chk("fullrw.b_in_ready", 32'(b_in_ready), 32'd1);
        chk("fullrw.a_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("fullrw.b_count", 32'(b_count), 32'd5);
        chk("fullrw.a_count", 32'(a_count), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("fullrw.drain", 32'(b_out_data), 32'(exp3[i]));
            tick();
        end
        out_ready = 1'b0;

        // Flush discards contents
        fill(8'h31, 3);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1;
        chk("flush.a_in_ready", 32'(a_in_ready), 32'd0);
        chk("flush.b_out_valid", 32'(b_out_valid), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush.a_count", 32'(a_count), 32'd0);
        chk("flush.a_out_valid", 32'(a_out_valid), 32'd0);
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        #1;
        chk("flush.first", 32'(a_out_data), 32'h77);
        chk("flush.first_b", 32'(b_out_data), 32'h77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-stream
        fill(8'h41, 3);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("midrst.b_in_ready", 32'(b_in_ready), 32'd0);
        chk("midrst.b_out_valid", 32'(b_out_valid), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("midrst.a_count", 32'(a_count), 32'd0);
        chk("midrst.a_out_valid", 32'(a_out_valid), 32'd0);

        // Randomized traffic checked by the model
        pv = 50; pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                pv = int'($urandom_range(10, 90));
                pr = int'($urandom_range(10, 90));
                af_level = 3'($urandom_range(0, 7));
                ae_level = 3'($urandom_range(0, 7));
            end
            in_valid  = ($urandom_range(0, 99) < pv);
            out_ready = ($urandom_range(0, 99) < pr);
            flush     = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 199) == 0);
            in_data   = 8'($urandom);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
